frame_tx: RTL

Command-frame transmitter: the initiator for the board's byte-stream memory-access protocol. It accepts a write or read request (12-bit address, plus data bytes or a 16-bit read length) and emits the byte sequence the on-board frame decoder consumes. Its output feeds a UART transmitter or a loopback path over a valid/ready byte interface. It is used for board-to-board links and self-test of the decoder.

---
 rtl/frame_pkg.sv | 31 +++
 rtl/frame_tx_outreg.sv | 27 ++
 rtl/frame_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - frame protocol constants, state codes and address split shared with the decoder
package frame_pkg;

  localparam logic [7:0] START_BYTE1 = 8'h19;
  localparam logic [7:0] START_BYTE2 = 8'h1E;
  localparam logic [7:0] STOP_BYTE   = 8'h1C;

  localparam int ADDR_W   = 12;
  localparam int AHI_BITS = 5;
  localparam int ALO_BITS = 7;

  // Enum values double as the stateop debug codes.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'hF,
    ST_SB1   = 4'h1,
    ST_SB2   = 4'h2,
    ST_AHI   = 4'h3,
    ST_ALO   = 4'h4,
    ST_WDATA = 4'h5,
    ST_STOP  = 4'h6,
    ST_LHI   = 4'h7,
    ST_LLO   = 4'h8,
    ST_DRAIN = 4'h9
  } state_t;

  // {AHI, ALO}: AHI = zero-padded addr top bits, ALO = addr low bits with rw in bit 0.
  function automatic logic [15:0] addr_bytes(input logic [ADDR_W-1:0] addr, input logic rw);
    return {{(8-AHI_BITS){1'b0}}, addr[ADDR_W-1 -: AHI_BITS], addr[ALO_BITS-1:0], rw};
  endfunction

endpackage

// File: rtl/frame_tx_outreg.sv
// rtl/frame_tx_outreg.sv - tx_data/tx_valid holding register; holds its byte until the sink takes it
module frame_tx_outreg (
  input  logic       clk,
  input  logic       reset_in,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       can_load
);

  assign can_load = !tx_valid || tx_ready;

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_tx.sv
// rtl/frame_tx.sv - command-frame transmitter: sync bytes, address, then payload+stop or read length
// Optional FRAME_TX_STOP_GUARD_EN: a STOP_BYTE in the payload closes the frame, pulses err, drains the rest.
module frame_tx
  import frame_pkg::*;
(
  input  logic              clk,
  input  logic              reset_in,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_len,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  input  logic              wr_last,
  output logic              wr_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        stateop
);

  state_t            state_q, state_d;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       len_q;
  logic              stop_q, stop_d;  // STOP_BYTE is already sitting in the output register
  logic              done_q, done_d;
  logic              load;
  logic [7:0]        load_data;
  logic              can_load;
  logic              hs;
  logic              wr_take;
  logic [15:0]       hdr;
`ifdef FRAME_TX_STOP_GUARD_EN
  logic              abort_q, abort_d;
  logic              drain_q, drain_d;
  logic              err_q, err_d;
`endif

  frame_tx_outreg u_outreg (
    .clk       (clk),
    .reset_in  (reset_in),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .can_load  (can_load)
  );

  assign hs      = tx_valid && tx_ready;
  assign hdr     = addr_bytes(addr_q, rw_q);
  assign wr_take = wr_valid && wr_ready && (state_q == ST_ALO || state_q == ST_WDATA);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
`ifdef FRAME_TX_STOP_GUARD_EN
      abort_q <= 1'b0;
      drain_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
`ifdef FRAME_TX_STOP_GUARD_EN
      abort_q <= abort_d;
      drain_q <= drain_d;
      err_q   <= err_d;
`endif
      if (state_q == ST_IDLE && req_valid) begin
        rw_q   <= req_rw;
        addr_q <= req_addr;
        len_q  <= req_len;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
`ifdef FRAME_TX_STOP_GUARD_EN
    abort_d = abort_q;
    drain_d = drain_q;
`endif
    case (state_q)
      ST_IDLE: begin
        stop_d = 1'b0;
`ifdef FRAME_TX_STOP_GUARD_EN
        abort_d = 1'b0;
        drain_d = 1'b0;
`endif
        if (req_valid) state_d = ST_SB1;
      end
      ST_SB1:   if (hs) state_d = ST_SB2;
      ST_SB2:   if (hs) state_d = ST_AHI;
      ST_AHI:   if (hs) state_d = ST_ALO;
      ST_ALO:   if (hs) state_d = rw_q ? ST_WDATA : ST_LHI;
      ST_WDATA: state_d = state_q;
      ST_STOP: begin
        if (!stop_q) begin
          if (can_load) stop_d = 1'b1;
        end else if (hs) begin
`ifdef FRAME_TX_STOP_GUARD_EN
          state_d = (abort_q && drain_q) ? ST_DRAIN : ST_IDLE;
`else
          state_d = ST_IDLE;
`endif
        end
      end
      ST_LHI:   if (hs) state_d = ST_LLO;
      ST_LLO:   if (hs) state_d = ST_IDLE;
`ifdef FRAME_TX_STOP_GUARD_EN
      ST_DRAIN: if (wr_valid && wr_last) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
    if (wr_take) begin
      if (wr_last) state_d = ST_STOP;
`ifdef FRAME_TX_STOP_GUARD_EN
      if (wr_data == STOP_BYTE) begin
        state_d = ST_STOP;
        stop_d  = 1'b1;
        abort_d = 1'b1;
        drain_d = !wr_last;
      end
`endif
    end
  end

  // ALO of a write also accepts the first payload byte on its handshake so payload follows without a bubble.
  always_comb begin
    load      = 1'b0;
    load_data = 8'h00;
    wr_ready  = 1'b0;
    done_d    = 1'b0;
`ifdef FRAME_TX_STOP_GUARD_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (req_valid) begin load = 1'b1; load_data = START_BYTE1; end
      ST_SB1:  if (hs) begin load = 1'b1; load_data = START_BYTE2; end
      ST_SB2:  if (hs) begin load = 1'b1; load_data = hdr[15:8]; end
      ST_AHI:  if (hs) begin load = 1'b1; load_data = hdr[7:0]; end
      ST_ALO: begin
        if (rw_q) wr_ready = can_load;
        else if (hs) begin load = 1'b1; load_data = len_q[15:8]; end
      end
      ST_WDATA: wr_ready = can_load;
      ST_STOP: begin
        if (!stop_q) begin
          if (can_load) begin load = 1'b1; load_data = STOP_BYTE; end
        end else if (hs) begin
`ifdef FRAME_TX_STOP_GUARD_EN
          done_d = !abort_q;
          err_d  = abort_q;
`else
          done_d = 1'b1;
`endif
        end
      end
      ST_LHI:  if (hs) begin load = 1'b1; load_data = len_q[7:0]; end
      ST_LLO:  if (hs) done_d = 1'b1;
`ifdef FRAME_TX_STOP_GUARD_EN
      ST_DRAIN: wr_ready = 1'b1;
`endif
      default: load = 1'b0;
    endcase
    // A guarded STOP_BYTE payload byte already equals the terminator, so it loads unchanged.
    if (wr_take) begin
      load      = 1'b1;
      load_data = wr_data;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign stateop   = state_q;
`ifdef FRAME_TX_STOP_GUARD_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule
